apb_master_bridge: RTL

Upstream stage of every APB peripheral in the SoC (GPIO, future UART/timer). Converts single-cycle CPU load/store requests into APB SETUP/ACCESS transfers and decodes the address to one of four slave selects. Muxes the selected slave's PRDATA/PREADY back to the CPU. Ends each transfer with an error response on decode miss or slave timeout.

---
 rtl/apb_master_bridge.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB bridge: decodes four 4 KiB slave windows at 0x1000_0000 and
// runs SETUP/ACCESS with a wait-state timeout; completion is a combinational one-cycle ready pulse.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_e;

  localparam logic [7:0] TO_LIMIT = TIMEOUT[7:0];

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;

  logic        addr_hit;
  logic        slv_rdy;
  logic [31:0] slv_rdata;
  logic [3:0]  psel_vec;

  // Windows 0x1000_0000..0x1000_3FFF: addr[31:12] in 0x10000..0x10003.
  assign addr_hit = (addr[31:14] == 18'h04000);

  always_comb begin
    slv_rdy   = 1'b0;
    slv_rdata = 32'h0;
    case (sel_q)
      2'd0: begin slv_rdy = PREADY0; slv_rdata = PRDATA0; end
      2'd1: begin slv_rdy = PREADY1; slv_rdata = PRDATA1; end
      2'd2: begin slv_rdy = PREADY2; slv_rdata = PRDATA2; end
      default: begin slv_rdy = PREADY3; slv_rdata = PRDATA3; end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= 8'h0;
      sel_q    <= 2'd0;
      paddr_q  <= 32'h0;
      pwdata_q <= 32'h0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    ready    = 1'b0;
    err      = 1'b0;
    rdata    = 32'h0;
    psel_vec = 4'b0000;
    PENABLE  = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (addr_hit) begin
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = write;
            sel_d    = addr[13:12];
            state_d  = SETUP;
          end else begin
            state_d = DERR;
          end
        end
      end
      SETUP: begin
        psel_vec[sel_q] = 1'b1;
        cnt_d           = 8'h0;
        state_d         = ACCESS;
      end
      ACCESS: begin
        psel_vec[sel_q] = 1'b1;
        PENABLE         = 1'b1;
        // A ready slave takes priority over an expiring timeout.
        if (slv_rdy) begin
          ready   = 1'b1;
          rdata   = pwrite_q ? 32'h0 : slv_rdata;
          state_d = IDLE;
        end else if (cnt_q == TO_LIMIT) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DERR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign PSEL0  = psel_vec[0];
  assign PSEL1  = psel_vec[1];
  assign PSEL2  = psel_vec[2];
  assign PSEL3  = psel_vec[3];
  assign PADDR  = paddr_q;
  assign PWDATA = pwdata_q;
  assign PWRITE = pwrite_q;

endmodule
